// File: rtl/mem_copy_master.sv
// Bus initiator that copies a block of words between two addresses using one read and one write cycle per word.
// Defining MEM_COPY_FILL_EN adds fill mode, which writes a constant pattern and skips every read.
module mem_copy_master #(
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                  CLK,
   input  logic                  RST_n,
   input  logic                  start_i,
   input  logic [31:0]           src_addr_i,
   input  logic [31:0]           dst_addr_i,
   input  logic [LEN_WIDTH-1:0]  len_i,
`ifdef MEM_COPY_FILL_EN
   input  logic                  fill_i,
   input  logic [DATA_WIDTH-1:0] fill_data_i,
`endif
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o,
   output logic [31:0]           Address_o,
   output logic                  Write_Enable_o,
   output logic [DATA_WIDTH-1:0] Write_Data_o,
   input  logic [DATA_WIDTH-1:0] Read_Data_i
);

   localparam logic [31:0] RAM_BASE = 32'h1001_0000;

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t                state;
   logic [31:0]           src_q;
   logic [31:0]           dst_q;
   logic [LEN_WIDTH-1:0]  cnt_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  fill_q;
   logic                  fill_req;
   logic                  reject;
   logic                  last_word;

`ifdef MEM_COPY_FILL_EN
   assign fill_req = fill_i;
`else
   assign fill_req = 1'b0;
`endif

   // Fill transfers never read, so only the destination has to be aligned for them.
   assign reject    = (dst_addr_i < RAM_BASE) || (dst_addr_i[1:0] != 2'b00) ||
                      ((src_addr_i[1:0] != 2'b00) && !fill_req);
   assign last_word = (cnt_q == LEN_WIDTH'(1));

   assign Write_Data_o = data_q;

   // Bus outputs are registered together with the next state so each state drives its own cycle.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state          <= IDLE;
         src_q          <= '0;
         dst_q          <= '0;
         cnt_q          <= '0;
         data_q         <= '0;
         fill_q         <= 1'b0;
         busy_o         <= 1'b0;
         done_o         <= 1'b0;
         err_o          <= 1'b0;
         Address_o      <= '0;
         Write_Enable_o <= 1'b0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  src_q  <= src_addr_i;
                  dst_q  <= dst_addr_i;
                  cnt_q  <= len_i;
                  fill_q <= fill_req;
                  err_o  <= reject;
                  busy_o <= 1'b1;
`ifdef MEM_COPY_FILL_EN
                  if (fill_i) begin
                     data_q <= fill_data_i;
                  end
`endif
                  if (reject || (len_i == '0)) begin
                     state          <= DONE;
                     done_o         <= 1'b1;
                     Address_o      <= '0;
                     Write_Enable_o <= 1'b0;
                  end else if (fill_req) begin
                     state          <= WRITE;
                     Address_o      <= dst_addr_i;
                     Write_Enable_o <= 1'b1;
                  end else begin
                     state          <= READ;
                     Address_o      <= src_addr_i;
                     Write_Enable_o <= 1'b0;
                  end
               end
            end
            READ: begin
               data_q         <= Read_Data_i;
               state          <= WRITE;
               Address_o      <= dst_q;
               Write_Enable_o <= 1'b1;
            end
            WRITE: begin
               src_q <= src_q + 32'd4;
               dst_q <= dst_q + 32'd4;
               cnt_q <= cnt_q - LEN_WIDTH'(1);
               if (last_word) begin
                  state          <= DONE;
                  done_o         <= 1'b1;
                  Address_o      <= '0;
                  Write_Enable_o <= 1'b0;
               end else if (fill_q) begin
                  state          <= WRITE;
                  Address_o      <= dst_q + 32'd4;
                  Write_Enable_o <= 1'b1;
               end else begin
                  state          <= READ;
                  Address_o      <= src_q + 32'd4;
                  Write_Enable_o <= 1'b0;
               end
            end
            DONE: begin
               state          <= IDLE;
               busy_o         <= 1'b0;
               Address_o      <= '0;
               Write_Enable_o <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_copy_master.sv
// Bench for mem_copy_master: a small word memory plus a per-cycle expected bus trace built from the transfer rules.
// Fill-mode checks are compiled only when MEM_COPY_FILL_EN is defined.
module tb_mem_copy_master;

   localparam int LW = 8;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] data;
      logic        chk_data;
      logic        busy;
      logic        done;
      logic        err;
   } rec_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [31:0]   src = '0;
   logic [31:0]   dst = '0;
   logic [LW-1:0] len = '0;
`ifdef MEM_COPY_FILL_EN
   logic          fill = 1'b0;
   logic [31:0]   fill_data = '0;
`endif
   logic          busy;
   logic          done;
   logic          err;
   logic [31:0]   addr;
   logic          we;
   logic [31:0]   wdata;
   logic [31:0]   rdata;

   logic [31:0]   mem [0:1023];
   logic [31:0]   model_mem [0:1023];
   logic          load_en = 1'b0;
   logic [9:0]    load_idx = '0;
   logic [31:0]   load_data = '0;

   rec_t          q[$];
   logic          cur_err = 1'b0;
   logic          check_en = 1'b0;
   int            total = 0;
   int            bad = 0;

   always #5 clk = ~clk;

   mem_copy_master #(.DATA_WIDTH(32), .LEN_WIDTH(LW)) dut (
`ifdef MEM_COPY_FILL_EN
      .fill_i         (fill),
      .fill_data_i    (fill_data),
`endif
      .CLK            (clk),
      .RST_n          (rst_n),
      .start_i        (start),
      .src_addr_i     (src),
      .dst_addr_i     (dst),
      .len_i          (len),
      .busy_o         (busy),
      .done_o         (done),
      .err_o          (err),
      .Address_o      (addr),
      .Write_Enable_o (we),
      .Write_Data_o   (wdata),
      .Read_Data_i    (rdata)
   );

   // Distinct ROM and RAM words map to distinct slots for every address this bench uses.
   function automatic logic [9:0] idx(input logic [31:0] a);
      return {a[28], a[10:2]};
   endfunction

   assign rdata = mem[idx(addr)];

   always @(posedge clk) begin
      if (load_en) mem[load_idx] <= load_data;
      else if (we) mem[idx(addr)] <= wdata;
   end

   function automatic rec_t mk(input logic [31:0] a, input logic w, input logic [31:0] d,
                               input logic c, input logic b, input logic dn, input logic e);
      rec_t r;
      r.addr = a; r.we = w; r.data = d; r.chk_data = c; r.busy = b; r.done = dn; r.err = e;
      return r;
   endfunction

   task automatic checkOutput(input string name, input bit ok, input logic [67:0] act, input logic [67:0] exp);
      total++;
      if (!ok) begin
         bad++;
         $display("[TB] FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic compareLoop();
      rec_t r;
      bit   ok;
      forever begin
         @(negedge clk);
         if (check_en) begin
            if (q.size() > 0) r = q.pop_front();
            else r = mk(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, cur_err);
            ok = (busy === r.busy) && (done === r.done) && (err === r.err) &&
                 (addr === r.addr) && (we === r.we) && (!r.chk_data || (wdata === r.data));
            checkOutput("bus_cycle", ok, {busy, done, err, we, addr, wdata},
                        {r.busy, r.done, r.err, r.we, r.addr, r.data});
         end
      end
   endtask

   task automatic waitIdle();
      int waited = 0;
      while ((q.size() != 0) && (waited < 300)) begin
         @(posedge clk);
         waited++;
      end
      if (q.size() != 0) begin
         checkOutput("idle_timeout", 1'b0, 68'(q.size()), 68'h0);
         $display("test done: total=%0d bad=%0d", total, bad);
         $fatal(1, "[TB] transfer never drained");
      end
   endtask

   task automatic loadWord(input logic [9:0] i, input logic [31:0] v);
      load_idx  = i;
      load_data = v;
      load_en   = 1'b1;
      model_mem[i] = v;
      @(posedge clk);
      #1;
      load_en = 1'b0;
   endtask

   // Starts a transfer and appends the full expected bus trace, beginning with the sampling cycle.
   task automatic applyStimulus(input logic [31:0] s, input logic [31:0] d, input logic [LW-1:0] n,
                                input bit f, input logic [31:0] fd);
      bit          ff;
      bit          rej;
      logic [31:0] w;
      waitIdle();
      @(posedge clk);
      #1;
`ifdef MEM_COPY_FILL_EN
      ff = f;
      fill = f;
      fill_data = fd;
`else
      ff = 1'b0;
`endif
      start = 1'b1;
      src = s;
      dst = d;
      len = n;
      rej = (d < 32'h1001_0000) || (d[1:0] != 2'b00) || ((s[1:0] != 2'b00) && !ff);
      q.push_back(mk(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, cur_err));
      cur_err = rej;
      if (!rej) begin
         for (int k = 0; k < int'(n); k++) begin
            if (ff) begin
               w = fd;
            end else begin
               w = model_mem[idx(s + 32'(4 * k))];
               q.push_back(mk(s + 32'(4 * k), 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, rej));
            end
            q.push_back(mk(d + 32'(4 * k), 1'b1, w, 1'b1, 1'b1, 1'b0, rej));
            model_mem[idx(d + 32'(4 * k))] = w;
         end
      end
      q.push_back(mk(32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, rej));
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Observes the cycles after the sampling edge: first done cycle, write cycles, read cycles, address in cycle 3.
   task automatic watchXfer(input int cyc, output int done_at, output int we_cnt, output int rd_cnt,
                            output logic [31:0] addr3);
      done_at = 0;
      we_cnt  = 0;
      rd_cnt  = 0;
      addr3   = 32'hFFFF_FFFF;
      for (int c = 1; c <= cyc; c++) begin
         @(negedge clk);
         if (done && (done_at == 0)) done_at = c;
         if (we) we_cnt++;
         if (busy && !we && !done) rd_cnt++;
         if (c == 3) addr3 = addr;
      end
   endtask

   initial begin
      int          done_at;
      int          we_cnt;
      int          rd_cnt;
      int          dsum;
      logic [31:0] a3;
      logic [31:0] rs;
      logic [31:0] rd;
      logic [31:0] pre;
      bit          rf;

      fork
         compareLoop();
      join_none

      #1;
      checkOutput("reset_outputs", {busy, done, err, we, addr, wdata} == 68'h0,
                  {busy, done, err, we, addr, wdata}, 68'h0);

      for (int i = 0; i < 1024; i++) loadWord(10'(i), $urandom);
      @(negedge clk);
      rst_n = 1'b1;
      check_en = 1'b1;

      $display("[TB] basic copy");
      for (int i = 0; i < 4; i++) loadWord(10'(i), 32'hA0 + 32'(i));
      applyStimulus(32'h0040_0000, 32'h1001_0010, 8'd4, 1'b0, 32'h0);
      watchXfer(12, done_at, we_cnt, rd_cnt, a3);
      checkOutput("basic_done_cycle", done_at == 9, 68'(done_at), 68'd9);
      checkOutput("basic_write_count", we_cnt == 4, 68'(we_cnt), 68'd4);
      checkOutput("basic_read_count", rd_cnt == 4, 68'(rd_cnt), 68'd4);
      checkOutput("basic_err", err == 1'b0, 68'(err), 68'd0);
      for (int i = 0; i < 4; i++)
         checkOutput("basic_word", mem[idx(32'h1001_0010 + 32'(4 * i))] == 32'hA0 + 32'(i),
                     68'(mem[idx(32'h1001_0010 + 32'(4 * i))]), 68'(32'hA0 + 32'(i)));

      $display("[TB] start while busy");
      applyStimulus(32'h0040_0004, 32'h1001_0100, 8'd3, 1'b0, 32'h0);
      start = 1'b1;
      src = 32'h0040_0001;
      dst = 32'h0000_0000;
      len = 8'd1;
      @(posedge clk);
      #1;
      start = 1'b0;
      waitIdle();
      for (int i = 0; i < 3; i++)
         checkOutput("busy_start_word", mem[idx(32'h1001_0100 + 32'(4 * i))] == 32'hA1 + 32'(i),
                     68'(mem[idx(32'h1001_0100 + 32'(4 * i))]), 68'(32'hA1 + 32'(i)));

      $display("[TB] reject cases");
      applyStimulus(32'h0040_0000, 32'h1000_FFFC, 8'd3, 1'b0, 32'h0);
      watchXfer(4, done_at, we_cnt, rd_cnt, a3);
      checkOutput("rej_dst_done", done_at == 1, 68'(done_at), 68'd1);
      checkOutput("rej_dst_nowrite", we_cnt == 0, 68'(we_cnt), 68'd0);
      checkOutput("rej_dst_err", err == 1'b1, 68'(err), 68'd1);
      applyStimulus(32'h0040_0002, 32'h1001_0000, 8'd3, 1'b0, 32'h0);
      watchXfer(4, done_at, we_cnt, rd_cnt, a3);
      checkOutput("rej_src_done", done_at == 1, 68'(done_at), 68'd1);
      checkOutput("rej_src_nowrite", we_cnt == 0, 68'(we_cnt), 68'd0);
      checkOutput("rej_src_err", err == 1'b1, 68'(err), 68'd1);
      applyStimulus(32'h0040_0000, 32'h1001_0040, 8'd1, 1'b0, 32'h0);
      watchXfer(4, done_at, we_cnt, rd_cnt, a3);
      checkOutput("err_cleared", err == 1'b0, 68'(err), 68'd0);
      checkOutput("len1_done", done_at == 3, 68'(done_at), 68'd3);

      $display("[TB] zero length");
      applyStimulus(32'h0040_0000, 32'h1001_0080, 8'd0, 1'b0, 32'h0);
      watchXfer(4, done_at, we_cnt, rd_cnt, a3);
      checkOutput("zero_done", done_at == 1, 68'(done_at), 68'd1);
      checkOutput("zero_nowrite", we_cnt == 0, 68'(we_cnt), 68'd0);
      checkOutput("zero_err", err == 1'b0, 68'(err), 68'd0);

      $display("[TB] reset mid transfer");
      waitIdle();
      check_en = 1'b0;
      pre = model_mem[idx(32'h1001_0184)];
      @(posedge clk);
      #1;
      start = 1'b1;
      src = 32'h0040_0000;
      dst = 32'h1001_0180;
      len = 8'd4;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      checkOutput("rst_second_write", (we == 1'b1) && (addr == 32'h1001_0184),
                  68'({we, addr}), 68'({1'b1, 32'h1001_0184}));
      rst_n = 1'b0;
      #1;
      checkOutput("rst_async", {busy, done, we, addr} == 35'h0, 68'({busy, done, we, addr}), 68'h0);
      dsum = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (done) dsum++;
      end
      rst_n = 1'b1;
      checkOutput("rst_no_done", dsum == 0, 68'(dsum), 68'd0);
      checkOutput("rst_word0", mem[idx(32'h1001_0180)] == 32'hA0, 68'(mem[idx(32'h1001_0180)]), 68'(32'hA0));
      checkOutput("rst_word1_untouched", mem[idx(32'h1001_0184)] == pre,
                  68'(mem[idx(32'h1001_0184)]), 68'(pre));
      model_mem[idx(32'h1001_0180)] = 32'hA0;
      cur_err = 1'b0;
      q.delete();
      check_en = 1'b1;

      $display("[TB] address wrap");
      applyStimulus(32'hFFFF_FFFC, 32'h1001_0200, 8'd2, 1'b0, 32'h0);
      watchXfer(6, done_at, we_cnt, rd_cnt, a3);
      checkOutput("wrap_second_read", a3 == 32'h0, 68'(a3), 68'h0);
      checkOutput("wrap_done", done_at == 5, 68'(done_at), 68'd5);

`ifdef MEM_COPY_FILL_EN
      $display("[TB] fill mode");
      applyStimulus(32'h0040_0000, 32'h1001_0000, 8'd3, 1'b1, 32'hDEAD_BEEF);
      watchXfer(6, done_at, we_cnt, rd_cnt, a3);
      checkOutput("fill_done", done_at == 4, 68'(done_at), 68'd4);
      checkOutput("fill_writes", we_cnt == 3, 68'(we_cnt), 68'd3);
      checkOutput("fill_no_reads", rd_cnt == 0, 68'(rd_cnt), 68'd0);
      applyStimulus(32'h0040_0003, 32'h1001_0020, 8'd2, 1'b1, 32'h1234_5678);
      watchXfer(4, done_at, we_cnt, rd_cnt, a3);
      checkOutput("fill_src_unaligned_ok", err == 1'b0, 68'(err), 68'd0);
`endif

      $display("[TB] random transfers");
      for (int t = 0; t < 40; t++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: rs = 32'h0040_0000 + 32'(4 * $urandom_range(0, 31));
            6, 7, 8:          rs = 32'h1001_0000 + 32'(4 * $urandom_range(0, 63));
            default:          rs = 32'h0040_0000 + 32'($urandom_range(1, 3));
         endcase
         case ($urandom_range(0, 9))
            0:       rd = 32'h1000_FFF0;
            1:       rd = 32'h1001_0002 + 32'(4 * $urandom_range(0, 63));
            default: rd = 32'h1001_0000 + 32'(4 * $urandom_range(0, 63));
         endcase
         rf = ($urandom_range(0, 3) == 0);
         applyStimulus(rs, rd, LW'($urandom_range(0, 6)), rf, $urandom);
      end
      waitIdle();
      repeat (3) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
